// File: rtl/wqe_cache_mc.sv
// wqe_cache_mc: multi-class WQE cache. Incoming WQEs are steered by a
// programmable QPN->class table into per-class FIFOs, and a weighted
// round-robin arbiter drains them on scheduler read requests.
module wqe_cache_mc #(
  parameter int WQE_WIDTH     = 512,
  parameter int QP_PTR_WIDTH  = 4,
  parameter int QPID_LSB      = 328,
  parameter int WRID_LSB      = 0,
  parameter int NUM_CLASS     = 4,
  parameter int DEPTH_LOG2    = 4,
  parameter int ALFULL_MARGIN = 2,
  parameter int WEIGHT_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wqe_cache_wr,
  input  logic [WQE_WIDTH-1:0]         i_wqe,
  output logic                         o_wqe_cache_alfull,
  output logic [NUM_CLASS-1:0]         o_class_alfull,
  output logic                         o_wqe_cache_empty,
  input  logic                         i_wqe_cache_rd,
  output logic                         o_wqe_val,
  output logic [WQE_WIDTH-1:0]         o_wqe,
  output logic [$clog2(NUM_CLASS)-1:0] o_wqe_class,
  output logic                         o_wqe_cache_wr_val,
  output logic [QP_PTR_WIDTH-1:0]      o_wqe_cache_wr_qpn,
  output logic [63:0]                  o_wqe_cache_wr_wrid,
  output logic                         o_wqe_drop,
  input  logic                         i_cfg_map_wr,
  input  logic [QP_PTR_WIDTH-1:0]      i_cfg_map_qpn,
  input  logic [$clog2(NUM_CLASS)-1:0] i_cfg_map_class,
  input  logic                         i_cfg_wgt_wr,
  input  logic [$clog2(NUM_CLASS)-1:0] i_cfg_wgt_class,
  input  logic [WEIGHT_WIDTH-1:0]      i_cfg_wgt
);

  localparam int CLS_W = $clog2(NUM_CLASS);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int MAP_N = 1 << QP_PTR_WIDTH;

  localparam logic [DEPTH_LOG2:0]   OCC_FULL   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   OCC_ALFULL = (DEPTH_LOG2+1)'(DEPTH - ALFULL_MARGIN);
  localparam logic [DEPTH_LOG2:0]   OCC_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [WEIGHT_WIDTH-1:0] CNT_ONE  = WEIGHT_WIDTH'(1);
  localparam logic [CLS_W:0]        NCLS       = (CLS_W+1)'(NUM_CLASS);

  // A programmed weight of zero still earns one grant per round.
  function automatic logic [WEIGHT_WIDTH-1:0] wgt_eff(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? CNT_ONE : w;
  endfunction

  // Configuration state
  logic [CLS_W-1:0]        map_q [MAP_N];
  logic [WEIGHT_WIDTH-1:0] wgt_q [NUM_CLASS];

  // Per-class FIFO storage and bookkeeping
  logic [WQE_WIDTH-1:0]    mem_q  [NUM_CLASS][DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr_q [NUM_CLASS];
  logic [DEPTH_LOG2-1:0]   rptr_q [NUM_CLASS];
  logic [DEPTH_LOG2:0]     occ_q  [NUM_CLASS];
  logic [DEPTH_LOG2:0]     occ_d  [NUM_CLASS];

  // Arbiter state
  logic [CLS_W-1:0]        ptr_q;
  logic [WEIGHT_WIDTH-1:0] cnt_q;

  // Registered outputs
  logic                    val_q;
  logic [WQE_WIDTH-1:0]    wqe_q;
  logic [CLS_W-1:0]        cls_q;
  logic                    empty_q;
  logic                    empty_d;
  logic [NUM_CLASS-1:0]    alfull_q;
  logic [NUM_CLASS-1:0]    alfull_d;

  // Combinational helpers
  logic [QP_PTR_WIDTH-1:0] wr_qpn;
  logic [CLS_W-1:0]        wr_cls;
  logic                    wr_full;
  logic                    push;
  logic [NUM_CLASS-1:0]    nonempty;
  logic                    rd_fire;
  logic                    stay;
  logic                    found;
  logic [CLS_W-1:0]        cand;
  logic [CLS_W-1:0]        gnt;
  logic [NUM_CLASS-1:0]    push_sel;
  logic [NUM_CLASS-1:0]    pop_sel;
  logic                    cfg_map_ok;
  logic                    cfg_wgt_ok;

  // Write-side classification; the full decision uses registered occupancy,
  // so a same-cycle pop never rescues a push into a full class.
  assign wr_qpn  = i_wqe[QPID_LSB +: QP_PTR_WIDTH];
  assign wr_cls  = map_q[wr_qpn];
  assign wr_full = (occ_q[wr_cls] == OCC_FULL);
  assign push    = i_wqe_cache_wr && !wr_full;

  assign o_wqe_cache_wr_val  = push;
  assign o_wqe_drop          = i_wqe_cache_wr && wr_full;
  assign o_wqe_cache_wr_qpn  = wr_qpn;
  assign o_wqe_cache_wr_wrid = i_wqe[WRID_LSB +: 64];

  assign cfg_map_ok = ({1'b0, i_cfg_map_class} < NCLS);
  assign cfg_wgt_ok = ({1'b0, i_cfg_wgt_class} < NCLS);

  // Class is readable only once its push has landed in occupancy.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      nonempty[c] = (occ_q[c] != '0);
    end
  end

  assign rd_fire = i_wqe_cache_rd && (|nonempty);

  // WRR grant: stay on ptr while it has credit and data, otherwise scan
  // forward from ptr+1 and consider ptr itself last.
  always_comb begin
    stay  = nonempty[ptr_q] && (cnt_q < wgt_eff(wgt_q[ptr_q]));
    gnt   = ptr_q;
    found = 1'b0;
    cand  = ptr_q;
    if (!stay) begin
      for (int i = 1; i <= NUM_CLASS; i++) begin
        cand = CLS_W'((int'(ptr_q) + i) % NUM_CLASS);
        if (!found && nonempty[cand]) begin
          gnt   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Per-class push/pop strobes
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      push_sel[c] = push && (wr_cls == CLS_W'(c));
      pop_sel[c]  = rd_fire && (gnt == CLS_W'(c));
    end
  end

  // Next occupancy and the status flags derived from it
  always_comb begin
    empty_d  = 1'b1;
    alfull_d = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      occ_d[c] = occ_q[c];
      if (push_sel[c] && !pop_sel[c]) begin
        occ_d[c] = occ_q[c] + OCC_ONE;
      end else if (!push_sel[c] && pop_sel[c]) begin
        occ_d[c] = occ_q[c] - OCC_ONE;
      end
      if (occ_d[c] != '0) begin
        empty_d = 1'b0;
      end
      alfull_d[c] = (occ_d[c] >= OCC_ALFULL);
    end
  end

  // Map table and weights; out-of-range class indices are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < MAP_N; q++) begin
        map_q[q] <= CLS_W'(q % NUM_CLASS);
      end
      for (int c = 0; c < NUM_CLASS; c++) begin
        wgt_q[c] <= CNT_ONE;
      end
    end else begin
      if (i_cfg_map_wr && cfg_map_ok) begin
        map_q[i_cfg_map_qpn] <= i_cfg_map_class;
      end
      if (i_cfg_wgt_wr && cfg_wgt_ok) begin
        wgt_q[i_cfg_wgt_class] <= i_cfg_wgt;
      end
    end
  end

  // FIFO payload storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_cls][wptr_q[wr_cls]] <= i_wqe;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        occ_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        occ_q[c] <= occ_d[c];
        if (push_sel[c]) begin
          wptr_q[c] <= wptr_q[c] + PTR_ONE;
        end
        if (pop_sel[c]) begin
          rptr_q[c] <= rptr_q[c] + PTR_ONE;
        end
      end
    end
  end

  // Arbiter pointer and credit counter advance only on an actual grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (rd_fire) begin
      if (stay) begin
        cnt_q <= cnt_q + CNT_ONE;
      end else begin
        ptr_q <= gnt;
        cnt_q <= CNT_ONE;
      end
    end
  end

  // Read data stage: one-cycle valid pulse, data held between grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 1'b0;
      wqe_q <= '0;
      cls_q <= '0;
    end else begin
      val_q <= rd_fire;
      if (rd_fire) begin
        wqe_q <= mem_q[gnt][rptr_q[gnt]];
        cls_q <= gnt;
      end
    end
  end

  // Status flags registered alongside occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_q  <= 1'b1;
      alfull_q <= '0;
    end else begin
      empty_q  <= empty_d;
      alfull_q <= alfull_d;
    end
  end

  assign o_wqe_val          = val_q;
  assign o_wqe              = wqe_q;
  assign o_wqe_class        = cls_q;
  assign o_wqe_cache_empty  = empty_q;
  assign o_class_alfull     = alfull_q;
  assign o_wqe_cache_alfull = |alfull_q;

endmodule

// File: tb/tb_wqe_cache_mc.sv
// tb_wqe_cache_mc: directed bench for wqe_cache_mc with a read scoreboard.
module tb_wqe_cache_mc;

  localparam int WW  = 512;
  localparam int QW  = 4;
  localparam int QL  = 328;
  localparam int NC  = 4;
  localparam int CW  = 2;
  localparam int WGW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_wqe_cache_wr;
  logic [WW-1:0]  i_wqe;
  logic           o_wqe_cache_alfull;
  logic [NC-1:0]  o_class_alfull;
  logic           o_wqe_cache_empty;
  logic           i_wqe_cache_rd;
  logic           o_wqe_val;
  logic [WW-1:0]  o_wqe;
  logic [CW-1:0]  o_wqe_class;
  logic           o_wqe_cache_wr_val;
  logic [QW-1:0]  o_wqe_cache_wr_qpn;
  logic [63:0]    o_wqe_cache_wr_wrid;
  logic           o_wqe_drop;
  logic           i_cfg_map_wr;
  logic [QW-1:0]  i_cfg_map_qpn;
  logic [CW-1:0]  i_cfg_map_class;
  logic           i_cfg_wgt_wr;
  logic [CW-1:0]  i_cfg_wgt_class;
  logic [WGW-1:0] i_cfg_wgt;

  always #5 clk = ~clk;

  wqe_cache_mc dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_wqe_cache_wr      (i_wqe_cache_wr),
    .i_wqe               (i_wqe),
    .o_wqe_cache_alfull  (o_wqe_cache_alfull),
    .o_class_alfull      (o_class_alfull),
    .o_wqe_cache_empty   (o_wqe_cache_empty),
    .i_wqe_cache_rd      (i_wqe_cache_rd),
    .o_wqe_val           (o_wqe_val),
    .o_wqe               (o_wqe),
    .o_wqe_class         (o_wqe_class),
    .o_wqe_cache_wr_val  (o_wqe_cache_wr_val),
    .o_wqe_cache_wr_qpn  (o_wqe_cache_wr_qpn),
    .o_wqe_cache_wr_wrid (o_wqe_cache_wr_wrid),
    .o_wqe_drop          (o_wqe_drop),
    .i_cfg_map_wr        (i_cfg_map_wr),
    .i_cfg_map_qpn       (i_cfg_map_qpn),
    .i_cfg_map_class     (i_cfg_map_class),
    .i_cfg_wgt_wr        (i_cfg_wgt_wr),
    .i_cfg_wgt_class     (i_cfg_wgt_class),
    .i_cfg_wgt           (i_cfg_wgt)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] cls;
    logic [WW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t          sb [$];
  logic [WW-1:0] mq [NC][$];
  int            map_m [16];
  logic [WW-1:0] last_wqe = '0;
  bit            prev_val = 1'b0;

  int t2_cls [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
  int t4_cls [4]  = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic [QW-1:0] qpn, input logic [63:0] tag);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
    w[QL +: QW] = qpn;
    w[63:0]     = tag;
    return w;
  endfunction

  // One cycle of stimulus; a read with rd_cls >= 0 queues its expected result.
  task automatic step(input bit wr, input logic [QW-1:0] qpn, input logic [63:0] tag,
                      input bit exp_acc, input bit rd, input int rd_cls);
    logic [WW-1:0] w;
    exp_t e;
    @(posedge clk); #1;
    w = mk(qpn, tag);
    i_wqe_cache_wr = wr;
    i_wqe          = w;
    i_wqe_cache_rd = rd;
    i_cfg_map_wr   = 1'b0;
    i_cfg_wgt_wr   = 1'b0;
    if (rd && rd_cls >= 0) begin
      e.cls  = CW'(rd_cls);
      e.data = mq[rd_cls].pop_front();
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    #1;
    if (wr) begin
      chk("wr_val",  WW'(o_wqe_cache_wr_val),  WW'(exp_acc));
      chk("wr_drop", WW'(o_wqe_drop),          WW'(!exp_acc));
      chk("wr_qpn",  WW'(o_wqe_cache_wr_qpn),  WW'(qpn));
      chk("wr_wrid", WW'(o_wqe_cache_wr_wrid), WW'(tag));
      if (exp_acc) mq[map_m[qpn]].push_back(w);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_wqe_cache_wr = 1'b0;
      i_wqe_cache_rd = 1'b0;
      i_cfg_map_wr   = 1'b0;
      i_cfg_wgt_wr   = 1'b0;
    end
  endtask

  task automatic cfg_map(input logic [QW-1:0] qpn, input int cls);
    @(posedge clk); #1;
    i_wqe_cache_wr  = 1'b0;
    i_wqe_cache_rd  = 1'b0;
    i_cfg_wgt_wr    = 1'b0;
    i_cfg_map_wr    = 1'b1;
    i_cfg_map_qpn   = qpn;
    i_cfg_map_class = CW'(cls);
    map_m[qpn]      = cls;
  endtask

  task automatic cfg_wgt(input int cls, input logic [WGW-1:0] w);
    @(posedge clk); #1;
    i_wqe_cache_wr  = 1'b0;
    i_wqe_cache_rd  = 1'b0;
    i_cfg_map_wr    = 1'b0;
    i_cfg_wgt_wr    = 1'b1;
    i_cfg_wgt_class = CW'(cls);
    i_cfg_wgt       = w;
  endtask

  // Output monitor: every valid must match the oldest due scoreboard entry.
  always @(negedge clk) begin
    bit   due_now;
    exp_t e;
    due_now = (sb.size() > 0) && (sb[0].due == cyc);
    if (!rst_n) begin
      prev_val = 1'b0;
    end else begin
      if (due_now || o_wqe_val !== 1'b0) begin
        chk("rd_val", WW'(o_wqe_val), WW'(due_now));
        if (due_now) begin
          e = sb.pop_front();
          chk("rd_class", WW'(o_wqe_class), WW'(e.cls));
          chk("rd_data", o_wqe, e.data);
          last_wqe = e.data;
        end
      end else if (prev_val) begin
        chk("rd_hold", o_wqe, last_wqe);
      end
      prev_val = o_wqe_val;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] exp_af;
    int guard;
    rst_n           = 1'b0;
    i_wqe_cache_wr  = 1'b0;
    i_wqe           = '0;
    i_wqe_cache_rd  = 1'b0;
    i_cfg_map_wr    = 1'b0;
    i_cfg_map_qpn   = '0;
    i_cfg_map_class = '0;
    i_cfg_wgt_wr    = 1'b0;
    i_cfg_wgt_class = '0;
    i_cfg_wgt       = '0;
    for (int q = 0; q < 16; q++) map_m[q] = q % NC;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val",    WW'(o_wqe_val),          WW'(1'b0));
    chk("rst_wqe",    o_wqe,                   '0);
    chk("rst_class",  WW'(o_wqe_class),        WW'(2'd0));
    chk("rst_empty",  WW'(o_wqe_cache_empty),  WW'(1'b1));
    chk("rst_alfull", WW'(o_wqe_cache_alfull), WW'(1'b0));
    chk("rst_calf",   WW'(o_class_alfull),     WW'(4'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // Default map round robin
    for (int q = 0; q < 8; q++) step(1'b1, QW'(q), 64'(100 + q), 1'b1, 1'b0, -1);
    idle(1);
    chk("t1_not_empty", WW'(o_wqe_cache_empty), WW'(1'b0));
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, i % NC);
    idle(2);
    chk("t1_empty", WW'(o_wqe_cache_empty), WW'(1'b1));

    // Weighted round robin, weight 3 on class 0
    cfg_wgt(0, 4'd3);
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 4'd0 : 4'd4, 64'(200 + i), 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? 4'd1 : 4'd5, 64'(300 + i), 1'b1, 1'b0, -1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b0, 1'b1, t2_cls[i]);
    idle(2);
    cfg_wgt(0, 4'd0);

    // Fill class 2, almost-full and drop behaviour
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k % 2 == 0) ? 4'd2 : 4'd6, 64'(400 + k), 1'b1, 1'b0, -1);
      idle(1);
      exp_af    = '0;
      exp_af[2] = (k >= 13);
      chk("t3_class_alfull", WW'(o_class_alfull),     WW'(exp_af));
      chk("t3_alfull",       WW'(o_wqe_cache_alfull), WW'(exp_af[2]));
    end
    step(1'b1, 4'd2, 64'(416), 1'b0, 1'b0, -1);
    idle(1);
    chk("t3_full_alfull", WW'(o_class_alfull), WW'(4'b0100));
    step(1'b1, 4'd6, 64'(417), 1'b0, 1'b1, 2);
    for (int i = 0; i < 15; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 2);
    idle(2);
    chk("t3_empty",     WW'(o_wqe_cache_empty), WW'(1'b1));
    chk("t3_alf_clear", WW'(o_class_alfull),    WW'(4'd0));

    // Remap QPN 5 while class 1 holds its older WQEs
    step(1'b1, 4'd5, 64'(500), 1'b1, 1'b0, -1);
    step(1'b1, 4'd5, 64'(501), 1'b1, 1'b0, -1);
    cfg_map(4'd5, 0);
    step(1'b1, 4'd5, 64'(502), 1'b1, 1'b0, -1);
    step(1'b1, 4'd5, 64'(503), 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, t4_cls[i]);
    idle(2);

    // Reads with nothing queued, then same-cycle write and read
    step(1'b0, '0, '0, 1'b0, 1'b1, -1);
    step(1'b0, '0, '0, 1'b0, 1'b1, -1);
    step(1'b1, 4'd3, 64'(600), 1'b1, 1'b1, -1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 3);
    idle(3);
    chk("t5_hold", o_wqe, last_wqe);

    // Reset in the middle of traffic
    for (int q = 0; q < 5; q++) step(1'b1, QW'(q), 64'(700 + q), 1'b1, 1'b0, -1);
    idle(1);
    chk("t6_not_empty", WW'(o_wqe_cache_empty), WW'(1'b0));
    step(1'b0, '0, '0, 1'b0, 1'b1, -1);
    @(posedge clk); #1;
    i_wqe_cache_rd = 1'b0;
    chk("t6_pre_val", WW'(o_wqe_val), WW'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    for (int c = 0; c < NC; c++) mq[c].delete();
    for (int q = 0; q < 16; q++) map_m[q] = q % NC;
    chk("t6_empty", WW'(o_wqe_cache_empty), WW'(1'b1));
    chk("t6_val",   WW'(o_wqe_val),         WW'(1'b0));
    chk("t6_wqe",   o_wqe,                  '0);
    chk("t6_class", WW'(o_wqe_class),       WW'(2'd0));
    chk("t6_calf",  WW'(o_class_alfull),    WW'(4'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b1, -1);
    idle(2);
    chk("t6_still_empty", WW'(o_wqe_cache_empty), WW'(1'b1));
    step(1'b1, 4'd5, 64'(800), 1'b1, 1'b0, -1);
    step(1'b1, 4'd4, 64'(801), 1'b1, 1'b0, -1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1);
    idle(3);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    chk("sb_drained", WW'(sb.size()), WW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
